bitblade_slice_sequencer: RTL and testbench
===========================================

Name: bitblade_slice_sequencer

Overview:
- Front-end operand feeder for the BitBlade 2-bit bit-split dot-product lanes.
- Accepts one vector of N_DOT activations and N_DOT weights, each up to 8 bits, with per-transaction precision and signedness.
- Emits the 2-bit slice pairs beat by beat, with SignI/SignW and a shift amount, so the downstream multiply/adder tree and shift-accumulator can rebuild the full-precision dot product.
- Valid/ready handshake on both sides.

Parameters:
- N_DOT, 8, number of dot-product lanes.
- BITS_PARALLEL, 2, slice width in bits (fixed at 2 for this block).
- PREC_MAX, 8, maximum operand precision in bits.

Ports:
- i_CLK  input  1  clock; all logic on the rising edge.
- i_RST  input  1  synchronous reset, active-high.
- i_Valid  input  1  upstream operand vector valid.
- o_Ready  output  1  block can accept an operand vector.
- i_ActVec  input  N_DOT*PREC_MAX  activations; lane j is bits [8j+7:8j].
- i_WeightVec  input  N_DOT*PREC_MAX  weights, same lane layout.
- i_PrecA  input  2  activation precision code: 0=2b, 1=4b, 2=6b, 3=8b.
- i_PrecW  input  2  weight precision code, same encoding.
- i_SignedA  input  1  activations are two's complement.
- i_SignedW  input  1  weights are two's complement.
- o_Valid  output  1  slice beat valid.
- i_Ready  input  1  downstream accepts beat.
- o_Act  output  N_DOT*2  activation slice; lane j is bits [2j+1:2j].
- o_Weight  output  N_DOT*2  weight slice, same lane layout.
- o_SignI  output  1  activation slice is signed (top slice of a signed operand).
- o_SignW  output  1  weight slice is signed.
- o_Shift  output  4  left-shift for this beat's partial sum = 2*(ia+iw).
- o_First  output  1  first beat of a transaction.
- o_Last  output  1  last beat of a transaction.

Behaviour:
- Reset (i_RST high at a rising edge):
  - State goes to IDLE; ia, iw and all captured registers cleared.
  - o_Valid=0, o_Act=0, o_Weight=0, o_SignI=0, o_SignW=0, o_Shift=0, o_First=0, o_Last=0.
  - o_Ready=0 while i_RST is high, 1 in the first cycle after reset.
  - Reset mid-transaction aborts it: no further beats; a pending beat is dropped.
- States:
  - IDLE: o_Ready=1, o_Valid=0.
  - RUN: o_Ready=0 (see Optional Feature), o_Valid=1.
- IDLE->RUN: on i_Valid & o_Ready, capture both vectors, precisions and sign flags. Set NA=i_PrecA+1 and NW=i_PrecW+1, ia=0, iw=0.
- First beat is presented the cycle after capture (latency 1).
- Beat order: ia is the inner loop, iw the outer. Total beats NA*NW, range 1..16.
- Beat fields:
  - o_Act lane j = act[j][2ia+1:2ia]; o_Weight lane j = wgt[j][2iw+1:2iw].
  - Bits above 2*NA (activations) or 2*NW (weights) are ignored.
  - o_SignI = SignedA & (ia==NA-1); o_SignW = SignedW & (iw==NW-1).
  - o_Shift = 2*(ia+iw), range 0..12.
  - o_First = (ia==0 & iw==0); o_Last = (ia==NA-1 & iw==NW-1).
- All beat outputs are decoded from registered state only; no combinational path from i_ActVec/i_WeightVec to any output.
- Beat fires on o_Valid & i_Ready:
  - If not last: ia increments; when ia wraps from NA-1 to 0, iw increments.
  - If last: RUN->IDLE.
- Backpressure: while o_Valid & ~i_Ready, all beat outputs hold stable; counters hold.
- i_Valid while o_Ready=0 is ignored. Upstream must hold data until o_Ready is seen.
- 2b x 2b transaction is a single beat with o_First=o_Last=1.

Optional Feature:
- Macro SLICE_SEQ_BACK2BACK_EN.
- Defined:
  - o_Ready = IDLE | (RUN & o_Last & i_Ready). This is the only combinational ready path.
  - A capture coinciding with the last fire reloads registers and counters; state stays RUN, so the next transaction's first beat follows with no bubble.
- Undefined:
  - o_Ready = (state==IDLE) only.
  - At least one idle cycle with o_Valid=0 between transactions.

Test Plan:
- 8b signed act (PrecA=3, SignedA=1), lane0=0xB4; 2b signed wgt (PrecW=0, SignedW=1), lane0=0x03; i_Ready=1 -> 4 beats:
  - lane0 o_Act = 00, 01, 11, 10.
  - o_Weight=11 on all beats; o_SignW=1 on all beats.
  - o_SignI=0,0,0,1; o_Shift=0,2,4,6.
  - o_First on beat 1 only; o_Last on beat 4 only.
- 4b x 4b unsigned, lane3 act=0x9, wgt=0x6 -> 4 beats:
  - (ia,iw)=(0,0),(1,0),(0,1),(1,1); o_Shift=0,2,2,4.
  - lane3 act slices 01,10,01,10; wgt slices 10,10,01,01; SignI=SignW=0.
- Backpressure: same stimulus as scenario 2, i_Ready low for 3 cycles during beat 2 -> beat-2 outputs constant for 4 cycles; total 4 fires, no duplicate or skipped beat.
- Reset mid-run: assert i_RST during beat 3 of an 8b x 8b transaction -> next cycle o_Valid=0, all outputs 0, o_Ready=1 after reset deasserts; a new 2b x 2b transaction produces exactly one beat.
- Back-to-back: two 2b x 4b transactions offered continuously, i_Ready=1:
  - Macro defined: 4 consecutive valid beats, no gap.
  - Macro undefined: one o_Valid=0 cycle between beat 2 and beat 3.
- Upper-bit masking: PrecA=0 with lane0 act=0xFE -> o_Act lane0=10, single beat, o_First=o_Last=1.

Source files
------------

// File: rtl/bitblade_slice_sequencer.sv
// Operand feeder for BitBlade 2-bit bit-split dot-product lanes: walks act/weight slice pairs.
// Optional macro SLICE_SEQ_BACK2BACK_EN allows a new vector to be captured on the last beat.
module bitblade_slice_sequencer #(
    parameter int unsigned N_DOT         = 8,
    parameter int unsigned BITS_PARALLEL = 2,
    parameter int unsigned PREC_MAX      = 8
) (
    input  logic                              i_CLK,
    input  logic                              i_RST,
    input  logic                              i_Valid,
    output logic                              o_Ready,
    input  logic [N_DOT*PREC_MAX-1:0]         i_ActVec,
    input  logic [N_DOT*PREC_MAX-1:0]         i_WeightVec,
    input  logic [1:0]                        i_PrecA,
    input  logic [1:0]                        i_PrecW,
    input  logic                              i_SignedA,
    input  logic                              i_SignedW,
    output logic                              o_Valid,
    input  logic                              i_Ready,
    output logic [N_DOT*BITS_PARALLEL-1:0]    o_Act,
    output logic [N_DOT*BITS_PARALLEL-1:0]    o_Weight,
    output logic                              o_SignI,
    output logic                              o_SignW,
    output logic [3:0]                        o_Shift,
    output logic                              o_First,
    output logic                              o_Last
);

    localparam int unsigned VEC_W   = N_DOT * PREC_MAX;
    localparam int unsigned SLICE_W = N_DOT * BITS_PARALLEL;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   act_q;
    logic [VEC_W-1:0]   wgt_q;
    logic [1:0]         na_m1;
    logic [1:0]         nw_m1;
    logic [1:0]         ia;
    logic [1:0]         iw;
    logic               signed_a;
    logic               signed_w;

    logic               capture;
    logic               fire;
    logic [1:0]         ia_nxt;
    logic [1:0]         iw_nxt;
    logic [1:0]         sel_ia;
    logic [1:0]         sel_iw;
    logic [1:0]         sel_na_m1;
    logic [1:0]         sel_nw_m1;
    logic               sel_sa;
    logic               sel_sw;
    logic [VEC_W-1:0]   src_act;
    logic [VEC_W-1:0]   src_wgt;
    logic [SLICE_W-1:0] nxt_act;
    logic [SLICE_W-1:0] nxt_wgt;
    logic               nxt_sign_i;
    logic               nxt_sign_w;
    logic [3:0]         nxt_shift;
    logic               nxt_first;
    logic               nxt_last;

`ifdef SLICE_SEQ_BACK2BACK_EN
    // Ready may rise combinationally on the final accepted beat so the next vector follows with no bubble.
    assign o_Ready = ~i_RST & ((state == IDLE) | ((state == RUN) & o_Last & i_Ready));
`else
    assign o_Ready = ~i_RST & (state == IDLE);
`endif

    assign capture = i_Valid & o_Ready;
    assign fire    = o_Valid & i_Ready;

    // Next beat decode: either beat (0,0) of a fresh capture or the successor of the current beat.
    always_comb begin
        ia_nxt     = '0;
        iw_nxt     = iw;
        src_act    = act_q;
        src_wgt    = wgt_q;
        sel_na_m1  = na_m1;
        sel_nw_m1  = nw_m1;
        sel_sa     = signed_a;
        sel_sw     = signed_w;
        nxt_act    = '0;
        nxt_wgt    = '0;

        if (ia == na_m1) begin
            ia_nxt = '0;
            iw_nxt = iw + 2'd1;
        end else begin
            ia_nxt = ia + 2'd1;
            iw_nxt = iw;
        end

        if (capture) begin
            src_act   = i_ActVec;
            src_wgt   = i_WeightVec;
            sel_na_m1 = i_PrecA;
            sel_nw_m1 = i_PrecW;
            sel_sa    = i_SignedA;
            sel_sw    = i_SignedW;
            sel_ia    = '0;
            sel_iw    = '0;
        end else begin
            sel_ia    = ia_nxt;
            sel_iw    = iw_nxt;
        end

        for (int j = 0; j < int'(N_DOT); j++) begin
            nxt_act[BITS_PARALLEL*j +: BITS_PARALLEL] =
                BITS_PARALLEL'(src_act[PREC_MAX*j +: PREC_MAX] >> (BITS_PARALLEL * sel_ia));
            nxt_wgt[BITS_PARALLEL*j +: BITS_PARALLEL] =
                BITS_PARALLEL'(src_wgt[PREC_MAX*j +: PREC_MAX] >> (BITS_PARALLEL * sel_iw));
        end

        nxt_sign_i = sel_sa & (sel_ia == sel_na_m1);
        nxt_sign_w = sel_sw & (sel_iw == sel_nw_m1);
        nxt_shift  = 4'(BITS_PARALLEL * (32'(sel_ia) + 32'(sel_iw)));
        nxt_first  = (sel_ia == 2'd0) & (sel_iw == 2'd0);
        nxt_last   = (sel_ia == sel_na_m1) & (sel_iw == sel_nw_m1);
    end

    // Sequencer FSM with registered beat outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state    <= IDLE;
            act_q    <= '0;
            wgt_q    <= '0;
            na_m1    <= '0;
            nw_m1    <= '0;
            ia       <= '0;
            iw       <= '0;
            signed_a <= 1'b0;
            signed_w <= 1'b0;
            o_Valid  <= 1'b0;
            o_Act    <= '0;
            o_Weight <= '0;
            o_SignI  <= 1'b0;
            o_SignW  <= 1'b0;
            o_Shift  <= '0;
            o_First  <= 1'b0;
            o_Last   <= 1'b0;
        end else if (capture) begin
            state    <= RUN;
            act_q    <= i_ActVec;
            wgt_q    <= i_WeightVec;
            na_m1    <= i_PrecA;
            nw_m1    <= i_PrecW;
            signed_a <= i_SignedA;
            signed_w <= i_SignedW;
            ia       <= '0;
            iw       <= '0;
            o_Valid  <= 1'b1;
            o_Act    <= nxt_act;
            o_Weight <= nxt_wgt;
            o_SignI  <= nxt_sign_i;
            o_SignW  <= nxt_sign_w;
            o_Shift  <= nxt_shift;
            o_First  <= nxt_first;
            o_Last   <= nxt_last;
        end else if (fire) begin
            if (o_Last) begin
                state    <= IDLE;
                o_Valid  <= 1'b0;
                o_Act    <= '0;
                o_Weight <= '0;
                o_SignI  <= 1'b0;
                o_SignW  <= 1'b0;
                o_Shift  <= '0;
                o_First  <= 1'b0;
                o_Last   <= 1'b0;
            end else begin
                ia       <= ia_nxt;
                iw       <= iw_nxt;
                o_Act    <= nxt_act;
                o_Weight <= nxt_wgt;
                o_SignI  <= nxt_sign_i;
                o_SignW  <= nxt_sign_w;
                o_Shift  <= nxt_shift;
                o_First  <= nxt_first;
                o_Last   <= nxt_last;
            end
        end
    end

endmodule

// File: tb/tb_bitblade_slice_sequencer.sv
// Scoreboard bench for bitblade_slice_sequencer: expected beats are modelled at vector acceptance.
module tb_bitblade_slice_sequencer;

    typedef struct packed {
        logic [15:0] act;
        logic [15:0] wgt;
        logic        si;
        logic        sw;
        logic [3:0]  shift;
        logic        first;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0] act;
        logic [63:0] wgt;
        logic [1:0]  pa;
        logic [1:0]  pw;
        logic        sa;
        logic        sw;
    } txn_t;

    logic        clk = 1'b0;
    logic        i_RST = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [63:0] i_ActVec = '0;
    logic [63:0] i_WeightVec = '0;
    logic [1:0]  i_PrecA = '0;
    logic [1:0]  i_PrecW = '0;
    logic        i_SignedA = 1'b0;
    logic        i_SignedW = 1'b0;
    logic        o_Valid;
    logic        i_Ready = 1'b1;
    logic [15:0] o_Act;
    logic [15:0] o_Weight;
    logic        o_SignI;
    logic        o_SignW;
    logic [3:0]  o_Shift;
    logic        o_First;
    logic        o_Last;

    int    total = 0;
    int    bad = 0;
    int    fires;
    bit    timed_out;
    txn_t  tx_q[$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t cyc_q[$];
    int    cyc_idx[$];
    logic  vtrace[$];

    always #5 clk = ~clk;

    bitblade_slice_sequencer dut (
        .i_CLK       (clk),
        .i_RST       (i_RST),
        .i_Valid     (i_Valid),
        .o_Ready     (o_Ready),
        .i_ActVec    (i_ActVec),
        .i_WeightVec (i_WeightVec),
        .i_PrecA     (i_PrecA),
        .i_PrecW     (i_PrecW),
        .i_SignedA   (i_SignedA),
        .i_SignedW   (i_SignedW),
        .o_Valid     (o_Valid),
        .i_Ready     (i_Ready),
        .o_Act       (o_Act),
        .o_Weight    (o_Weight),
        .o_SignI     (o_SignI),
        .o_SignW     (o_SignW),
        .o_Shift     (o_Shift),
        .o_First     (o_First),
        .o_Last      (o_Last)
    );

    function automatic beat_t cur_beat();
        beat_t b;
        b.act   = o_Act;
        b.wgt   = o_Weight;
        b.si    = o_SignI;
        b.sw    = o_SignW;
        b.shift = o_Shift;
        b.first = o_First;
        b.last  = o_Last;
        return b;
    endfunction

    // Reference model: weight index outer loop, activation index inner loop.
    function automatic void model_push(input txn_t t);
        beat_t b;
        for (int iw = 0; iw <= int'(t.pw); iw++) begin
            for (int ia = 0; ia <= int'(t.pa); ia++) begin
                for (int j = 0; j < 8; j++) begin
                    b.act[2*j +: 2] = t.act[8*j + 2*ia +: 2];
                    b.wgt[2*j +: 2] = t.wgt[8*j + 2*iw +: 2];
                end
                b.si    = t.sa && (ia == int'(t.pa));
                b.sw    = t.sw && (iw == int'(t.pw));
                b.shift = 4'(2 * (ia + iw));
                b.first = (ia == 0) && (iw == 0);
                b.last  = (ia == int'(t.pa)) && (iw == int'(t.pw));
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic txn_t mk_txn(input logic [63:0] a, input logic [63:0] w,
                                    input logic [1:0] pa, input logic [1:0] pw,
                                    input logic sa, input logic sw);
        txn_t t;
        t.act = a; t.wgt = w; t.pa = pa; t.pw = pw; t.sa = sa; t.sw = sw;
        return t;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Drives queued vectors and records every visible and accepted beat; stalls one chosen beat.
    task automatic run_engine(input int stall_at, input int stall_len, input int budget);
        int stalled = 0;
        int cyc = 0;
        fires = 0;
        timed_out = 1'b0;
        vtrace.delete(); cyc_q.delete(); cyc_idx.delete(); obs_q.delete(); exp_q.delete();
        forever begin
            @(posedge clk); #1;
            i_Valid = (tx_q.size() > 0);
            if (tx_q.size() > 0) begin
                i_ActVec = tx_q[0].act; i_WeightVec = tx_q[0].wgt;
                i_PrecA = tx_q[0].pa; i_PrecW = tx_q[0].pw;
                i_SignedA = tx_q[0].sa; i_SignedW = tx_q[0].sw;
            end
            if (o_Valid && fires == stall_at && stalled < stall_len) begin
                i_Ready = 1'b0;
                stalled++;
            end else begin
                i_Ready = 1'b1;
            end
            @(negedge clk);
            vtrace.push_back(o_Valid);
            if (o_Valid) begin
                cyc_q.push_back(cur_beat());
                cyc_idx.push_back(fires);
            end
            if (i_Valid && o_Ready) model_push(tx_q.pop_front());
            if (o_Valid && i_Ready) begin
                obs_q.push_back(cur_beat());
                fires++;
            end
            if (tx_q.size() == 0 && !o_Valid && fires == exp_q.size()) break;
            cyc++;
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        i_Valid = 1'b0;
        i_Ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (o_Ready !== 1'b0) begin bad++; $display("FAIL reset_ready_hi got=%b want=0", o_Ready); end
        @(posedge clk); #1;
        i_RST = 1'b0;
        @(negedge clk);
        total++;
        if (o_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready_lo got=%b want=1", o_Ready); end
        total++;
        if ({o_Valid, cur_beat()} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b_%h want=0", o_Valid, cur_beat());
        end
    endtask

    task automatic test_signed_8x2();
        beat_t o;
        beat_t e;
        logic [1:0] ea [4];
        logic       esi [4];
        logic [3:0] esh [4];
        ea  = '{2'b00, 2'b01, 2'b11, 2'b10};
        esi = '{1'b0, 1'b0, 1'b0, 1'b1};
        esh = '{4'd0, 4'd2, 4'd4, 4'd6};
        tx_q.push_back(mk_txn({rnd64() & 64'hFFFF_FFFF_FFFF_FF00} | 64'hB4,
                              {rnd64() & 64'hFFFF_FFFF_FFFF_FF00} | 64'h03, 2'd3, 2'd0, 1'b1, 1'b1));
        run_engine(-1, 0, 200);
        total++;
        if (timed_out !== 1'b0 || obs_q.size() != 4) begin
            bad++; $display("FAIL s8x2_count got=%0d want=4 timeout=%b", obs_q.size(), timed_out);
        end else begin
            for (int k = 0; k < 4; k++) begin
                o = obs_q[k];
                total++;
                if ({o.act[1:0], o.wgt[1:0], o.si, o.sw, o.shift, o.first, o.last} !==
                    {ea[k], 2'b11, esi[k], 1'b1, esh[k], k == 0, k == 3}) begin
                    bad++; $display("FAIL s8x2_beat%0d got=%h", k, o);
                end
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL s8x2_sb got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_unsigned_4x4(input int stall_len);
        beat_t o;
        beat_t e;
        int    n_b1;
        logic [1:0] ea [4];
        logic [1:0] ew [4];
        logic [3:0] esh [4];
        ea  = '{2'b01, 2'b10, 2'b01, 2'b10};
        ew  = '{2'b10, 2'b10, 2'b01, 2'b01};
        esh = '{4'd0, 4'd2, 4'd2, 4'd4};
        tx_q.push_back(mk_txn({8'h09, rnd64() & 64'h00FF_FFFF_FFFF_FFFF} & 64'h0FFF_FFFF_FFFF_FFFF,
                              {8'h06, rnd64() & 64'h00FF_FFFF} & 64'h0000_0006_FFFF_FFFF,
                              2'd1, 2'd1, 1'b0, 1'b0));
        tx_q[0].act[31:24] = 8'h09;
        tx_q[0].wgt[31:24] = 8'h06;
        run_engine(1, stall_len, 200);
        total++;
        if (timed_out !== 1'b0 || fires != 4) begin
            bad++; $display("FAIL u4x4_fires got=%0d want=4 timeout=%b", fires, timed_out);
        end else begin
            for (int k = 0; k < 4; k++) begin
                o = obs_q[k];
                total++;
                if ({o.act[7:6], o.wgt[7:6], o.si, o.sw, o.shift} !== {ea[k], ew[k], 2'b00, esh[k]}) begin
                    bad++; $display("FAIL u4x4_beat%0d got=%h", k, o);
                end
            end
        end
        if (stall_len > 0) begin
            n_b1 = 0;
            for (int c = 0; c < cyc_q.size(); c++) begin
                if (cyc_idx[c] == 1) begin
                    n_b1++;
                    total++;
                    if (obs_q.size() > 1 && cyc_q[c] !== obs_q[1]) begin
                        bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", c, cyc_q[c], obs_q[1]);
                    end
                end
            end
            total++;
            if (n_b1 != stall_len + 1) begin
                bad++; $display("FAIL bp_cycles got=%0d want=%0d", n_b1, stall_len + 1);
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL u4x4_sb got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_reset_mid_run();
        beat_t o;
        beat_t e;
        @(posedge clk); #1;
        i_ActVec = rnd64(); i_WeightVec = rnd64();
        i_PrecA = 2'd3; i_PrecW = 2'd3; i_SignedA = 1'b1; i_SignedW = 1'b1;
        i_Ready = 1'b1; i_Valid = 1'b1;
        @(posedge clk); #1;
        i_Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({o_Valid, o_Shift, o_First} !== {1'b1, 4'd4, 1'b0}) begin
            bad++; $display("FAIL rst_mid_beat3 got=%b_%0d_%b want=1_4_0", o_Valid, o_Shift, o_First);
        end
        i_RST = 1'b1;
        @(negedge clk);
        total++;
        if (o_Ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", o_Ready); end
        @(posedge clk); #1;
        i_RST = 1'b0;
        @(negedge clk);
        total++;
        if ({o_Valid, cur_beat()} !== '0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b_%h want=0", o_Valid, cur_beat());
        end
        total++;
        if (o_Ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after got=%b want=1", o_Ready); end
        tx_q.push_back(mk_txn(rnd64(), rnd64(), 2'd0, 2'd0, 1'b1, 1'b0));
        run_engine(-1, 0, 100);
        total++;
        if (timed_out !== 1'b0 || fires != 1) begin
            bad++; $display("FAIL rst_mid_after_fires got=%0d want=1 timeout=%b", fires, timed_out);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL rst_mid_sb got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        beat_t o;
        beat_t e;
        int first_v;
        int last_v;
        int gaps;
        int want_gaps;
`ifdef SLICE_SEQ_BACK2BACK_EN
        want_gaps = 0;
`else
        want_gaps = 1;
`endif
        tx_q.push_back(mk_txn(rnd64(), rnd64(), 2'd0, 2'd1, 1'b1, 1'b1));
        tx_q.push_back(mk_txn(rnd64(), rnd64(), 2'd0, 2'd1, 1'b0, 1'b1));
        run_engine(-1, 0, 200);
        first_v = -1; last_v = -1; gaps = 0;
        for (int c = 0; c < vtrace.size(); c++) begin
            if (vtrace[c] === 1'b1) begin
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        for (int c = first_v + 1; c < last_v; c++) if (vtrace[c] !== 1'b1) gaps++;
        total++;
        if (timed_out !== 1'b0 || fires != 4) begin
            bad++; $display("FAIL b2b_fires got=%0d want=4 timeout=%b", fires, timed_out);
        end
        total++;
        if (gaps != want_gaps) begin bad++; $display("FAIL b2b_gaps got=%0d want=%0d", gaps, want_gaps); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b_sb got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_mask_single();
        beat_t o;
        beat_t e;
        tx_q.push_back(mk_txn((rnd64() & 64'hFFFF_FFFF_FFFF_FF00) | 64'hFE, rnd64(), 2'd0, 2'd0, 1'b0, 1'b0));
        run_engine(-1, 0, 100);
        total++;
        if (timed_out !== 1'b0 || obs_q.size() != 1) begin
            bad++; $display("FAIL mask_count got=%0d want=1 timeout=%b", obs_q.size(), timed_out);
        end else begin
            o = obs_q[0];
            total++;
            if ({o.act[1:0], o.first, o.last, o.shift} !== {2'b10, 1'b1, 1'b1, 4'd0}) begin
                bad++; $display("FAIL mask_beat got=%h want act0=10 first=last=1", o);
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL mask_sb got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_random_stream();
        beat_t o;
        beat_t e;
        int    want = 0;
        for (int n = 0; n < 8; n++) begin
            tx_q.push_back(mk_txn(rnd64(), rnd64(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            want += (int'(tx_q[n].pa) + 1) * (int'(tx_q[n].pw) + 1);
        end
        run_engine(3, 2, 1000);
        total++;
        if (timed_out !== 1'b0 || fires != want) begin
            bad++; $display("FAIL rand_fires got=%0d want=%0d timeout=%b", fires, want, timed_out);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL rand_sb got=%h want=%h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_signed_8x2();
        test_unsigned_4x4(0);
        test_unsigned_4x4(3);
        test_reset_mid_run();
        test_back_to_back();
        test_mask_single();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
